// File: rtl/alu_share_arbiter_if.sv
// Purpose : request/response and ALU-side signal bundle for alu_share_arbiter.
// Signals : two requester channels (reqN_valid/ready/a/b/op), two response
//           channels (rspN_valid/ready) with a shared result and zero flag,
//           the ALU operand/select/result path and a busy indicator.
// Modports: slave  - the arbiter
//           master - the environment (requesters, responders, external ALU)
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_sel;
  logic [WIDTH-1:0] alu_result;

  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose : shares one external combinational ALU between two requesters.
//           Round-robin arbitration in IDLE, one EXEC cycle to capture the ALU
//           result, then RESP until the owning requester takes the result.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous, active-high reset
//           bus   - alu_share_arbiter_if.slave (request, response, ALU, busy)
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic                clk,
  input  logic                reset,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state,      w_state_nxt;
  logic             r_last_grant, w_last_grant_nxt;
  logic             r_owner,      w_owner_nxt;
  logic [WIDTH-1:0] r_alu_a,      w_alu_a_nxt;
  logic [WIDTH-1:0] r_alu_b,      w_alu_b_nxt;
  logic [OPW-1:0]   r_alu_sel,    w_alu_sel_nxt;
  logic [WIDTH-1:0] r_rsp_result, w_rsp_result_nxt;
  logic             r_rsp_zero,   w_rsp_zero_nxt;
  logic             r_rsp0_valid, w_rsp0_valid_nxt;
  logic             r_rsp1_valid, w_rsp1_valid_nxt;
  logic             r_busy,       w_busy_nxt;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_owner_rsp_ready;

  // Requester 0 wins unless requester 1 also asks and 0 was served last.
  assign w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
  assign w_grant1 = bus.req1_valid & ~w_grant0;

  // Only the owner's response ready can close a transaction.
  assign w_owner_rsp_ready = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

  // Next-state and next-register values; every register holds by default.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_owner_nxt      = r_owner;
    w_alu_a_nxt      = r_alu_a;
    w_alu_b_nxt      = r_alu_b;
    w_alu_sel_nxt    = r_alu_sel;
    w_rsp_result_nxt = r_rsp_result;
    w_rsp_zero_nxt   = r_rsp_zero;
    w_rsp0_valid_nxt = r_rsp0_valid;
    w_rsp1_valid_nxt = r_rsp1_valid;
    w_busy_nxt       = r_busy;
    w_req0_ready     = 1'b0;
    w_req1_ready     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_req0_ready = w_grant0;
        w_req1_ready = w_grant1;
        if (w_grant0 | w_grant1) begin
          w_owner_nxt      = w_grant1;
          w_last_grant_nxt = w_grant1;
          w_alu_a_nxt      = w_grant1 ? bus.req1_a  : bus.req0_a;
          w_alu_b_nxt      = w_grant1 ? bus.req1_b  : bus.req0_b;
          w_alu_sel_nxt    = w_grant1 ? bus.req1_op : bus.req0_op;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = S_EXEC;
        end
      end

      S_EXEC: begin
        w_rsp_result_nxt = bus.alu_result;
        w_rsp_zero_nxt   = (bus.alu_result == '0);
        w_rsp0_valid_nxt = ~r_owner;
        w_rsp1_valid_nxt = r_owner;
        w_state_nxt      = S_RESP;
      end

      S_RESP: begin
        if (w_owner_rsp_ready) begin
          w_rsp0_valid_nxt = 1'b0;
          w_rsp1_valid_nxt = 1'b0;
          w_busy_nxt       = 1'b0;
          w_state_nxt      = S_IDLE;
        end
      end

      default: begin
        w_rsp0_valid_nxt = 1'b0;
        w_rsp1_valid_nxt = 1'b0;
        w_busy_nxt       = 1'b0;
        w_state_nxt      = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_alu_a      <= w_alu_a_nxt;
      r_alu_b      <= w_alu_b_nxt;
      r_alu_sel    <= w_alu_sel_nxt;
      r_rsp_result <= w_rsp_result_nxt;
      r_rsp_zero   <= w_rsp_zero_nxt;
      r_rsp0_valid <= w_rsp0_valid_nxt;
      r_rsp1_valid <= w_rsp1_valid_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign bus.req0_ready = w_req0_ready;
  assign bus.req1_ready = w_req1_ready;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose : self-checking bench for alu_share_arbiter with an external ALU
//           model, directed vectors and a cycle-level random run.
module tb_alu_share_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned OW = 3;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(W), .OPW(OW)) bus ();

  alu_share_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state for the cycle-level run.
  bit          m_busy;
  bit          m_owner;
  bit          m_last;
  int          m_age;
  logic [31:0] m_exp;
  int          n_acc;
  int          n_done;
  int          cyc;
  bit          drop0;
  bit          drop1;
  int          g_who[$];
  int          g_cyc[$];

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return 32'(($signed(a) < $signed(b)) ? 1 : 0);
      default: return 32'h0;
    endcase
  endfunction

  // External ALU.
  assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_sel);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    check("rst_flags", 32'({bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_zero}), 32'h0);
    check("rst_alu_a", bus.alu_a, 32'h0);
    check("rst_alu_b", bus.alu_b, 32'h0);
    check("rst_alu_sel", 32'(bus.alu_sel), 32'h0);
    check("rst_result", bus.rsp_result, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    m_busy  = 1'b0;
    m_owner = 1'b0;
    m_last  = 1'b1;
    m_age   = 0;
    n_acc   = 0;
    n_done  = 0;
    cyc     = 0;
    drop0   = 1'b0;
    drop1   = 1'b0;
    g_who.delete();
    g_cyc.delete();
  endtask

  // Present a request and hold it until accepted; returns at the following negedge.
  task automatic issue(input bit who, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    int k;
    logic rdy;
    if (who) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
    #1;
    k   = 0;
    rdy = who ? bus.req1_ready : bus.req0_ready;
    while (!rdy && k < 8) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      k++;
      rdy = who ? bus.req1_ready : bus.req0_ready;
    end
    check(who ? "issue_rdy1" : "issue_rdy0", 32'(rdy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    if (who) bus.req1_valid = 1'b0;
    else     bus.req0_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, check it, and take it.
  task automatic await_rsp(input bit who, input logic [31:0] exp);
    int k;
    logic v;
    logic ov;
    #1;
    k = 0;
    v = who ? bus.rsp1_valid : bus.rsp0_valid;
    while (!v && k < 8) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      k++;
      v = who ? bus.rsp1_valid : bus.rsp0_valid;
    end
    ov = who ? bus.rsp0_valid : bus.rsp1_valid;
    check("rsp_valid", 32'(v), 32'h1);
    check("rsp_other_valid", 32'(ov), 32'h0);
    check("rsp_result", bus.rsp_result, exp);
    check("rsp_zero", 32'(bus.rsp_zero), 32'(exp == 32'h0));
    if (who) bus.rsp1_ready = 1'b1;
    else     bus.rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    check("rsp_drop", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'h0);
  endtask

  task automatic new_req(input bit who);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    if (who) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
      bus.req1_op = 3'($urandom_range(0, 5));
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
      bus.req0_op = 3'($urandom_range(0, 5));
    end
  endtask

  // Cycle-level run against the reference model.
  // mode 0: both requesters always valid, responders always ready
  // mode 1: random valid/ready
  // mode 2: drain (no new requests, responders ready)
  task automatic run_cycles(input int n, input int mode);
    logic [1:0] exp_rv;
    bit g0;
    bit g1;
    bit hs;
    for (int i = 0; i < n; i++) begin
      exp_rv = (m_busy && m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      check("cyc_rsp_v", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'(exp_rv));
      check("cyc_busy", 32'(bus.busy), 32'(m_busy));
      if (exp_rv != 2'b00) begin
        check("cyc_result", bus.rsp_result, m_exp);
        check("cyc_zero", 32'(bus.rsp_zero), 32'(m_exp == 32'h0));
      end
      if (drop0) begin bus.req0_valid = 1'b0; drop0 = 1'b0; end
      if (drop1) begin bus.req1_valid = 1'b0; drop1 = 1'b0; end
      if (mode == 0) begin
        if (!bus.req0_valid) new_req(1'b0);
        if (!bus.req1_valid) new_req(1'b1);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
      end else if (mode == 1) begin
        if (!bus.req0_valid && $urandom_range(0, 2) == 0) new_req(1'b0);
        if (!bus.req1_valid && $urandom_range(0, 2) == 0) new_req(1'b1);
        bus.rsp0_ready = 1'($urandom_range(0, 1));
        bus.rsp1_ready = 1'($urandom_range(0, 1));
      end else begin
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
      end
      #1;
      g0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
      g1 = !m_busy && bus.req1_valid && !g0;
      check("cyc_req_rdy", 32'({bus.req1_ready, bus.req0_ready}), 32'({g1, g0}));
      hs = (exp_rv[0] && bus.rsp0_ready) || (exp_rv[1] && bus.rsp1_ready);
      if (g0 || g1) begin
        m_busy  = 1'b1;
        m_age   = 1;
        m_owner = g1;
        m_last  = g1;
        m_exp   = g1 ? alu_ref(bus.req1_a, bus.req1_b, bus.req1_op)
                     : alu_ref(bus.req0_a, bus.req0_b, bus.req0_op);
        n_acc++;
        g_who.push_back(int'(g1));
        g_cyc.push_back(cyc);
        if (g0) drop0 = 1'b1;
        else    drop1 = 1'b1;
      end else if (m_busy) begin
        if (hs) begin
          m_busy = 1'b0;
          n_done++;
        end else begin
          m_age++;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (drop0) begin bus.req0_valid = 1'b0; drop0 = 1'b0; end
    if (drop1) begin bus.req1_valid = 1'b0; drop1 = 1'b0; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;

    // 1: single AND from requester 0, latency 2
    apply_reset();
    issue(1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, OP_AND);
    #1;
    check("t1_exec_rsp_v", 32'(bus.rsp0_valid), 32'h0);
    check("t1_exec_busy", 32'(bus.busy), 32'h1);
    check("t1_alu_a", bus.alu_a, 32'hF0F0F0F0);
    check("t1_alu_b", bus.alu_b, 32'h0FF00FF0);
    check("t1_alu_sel", 32'(bus.alu_sel), 32'(OP_AND));
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t1_cyc2_rsp_v", 32'(bus.rsp0_valid), 32'h1);
    await_rsp(1'b0, 32'h00F000F0);

    // 2: both always valid, responders always ready
    apply_reset();
    run_cycles(12, 0);
    run_cycles(20, 2);
    check("t2_ngrants", 32'(g_who.size() >= 4), 32'h1);
    if (g_who.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("t2_grant_order", 32'(g_who[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check("t2_accept_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end
    check("t2_all_done", 32'(n_done), 32'(n_acc));

    // 3: requester 1 stalled response, requester 0 waits
    apply_reset();
    bus.req1_valid = 1'b1; bus.req1_a = 32'hAAAAAAAA; bus.req1_b = 32'h55555555;
    bus.req1_op = OP_AND;
    #1;
    check("t3_rdy", 32'({bus.req1_ready, bus.req0_ready}), 32'b10);
    @(posedge clk);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h1; bus.req0_b = 32'h2; bus.req0_op = OP_OR;
    #1;
    check("t3_exec_rdy0", 32'(bus.req0_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_v", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'b10);
      check("t3_hold_result", bus.rsp_result, 32'h0);
      check("t3_hold_zero", 32'(bus.rsp_zero), 32'h1);
      check("t3_hold_busy", 32'(bus.busy), 32'h1);
      check("t3_hold_rdy0", 32'(bus.req0_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    #1;
    check("t3_done_v", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'b00);
    check("t3_done_busy", 32'(bus.busy), 32'h0);
    check("t3_rdy0_now", 32'(bus.req0_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    await_rsp(1'b0, 32'h3);

    // 4: reset during EXEC abandons the operation
    apply_reset();
    issue(1'b0, 32'h12345678, 32'h1, OP_ADD);
    reset = 1'b1;
    #1;
    check("t4_flags", 32'({bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_zero}), 32'h0);
    check("t4_alu_a", bus.alu_a, 32'h0);
    check("t4_alu_b", bus.alu_b, 32'h0);
    check("t4_alu_sel", 32'(bus.alu_sel), 32'h0);
    check("t4_result", bus.rsp_result, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_no_rsp", 32'({bus.busy, bus.rsp0_valid}), 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.req0_valid = 1'b1; bus.req0_a = 32'hFF; bus.req0_b = 32'h0F; bus.req0_op = OP_XOR;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h10; bus.req1_b = 32'h03; bus.req1_op = OP_SUB;
    #1;
    check("t4_tie", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    await_rsp(1'b0, 32'h000000F0);
    issue(1'b1, 32'h10, 32'h03, OP_SUB);
    await_rsp(1'b1, 32'h0000000D);

    // 5: ADD wrap, non-owner ready ignored
    apply_reset();
    issue(1'b0, 32'hFFFFFFFF, 32'h00000001, OP_ADD);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t5_v", 32'(bus.rsp0_valid), 32'h1);
    check("t5_result", bus.rsp_result, 32'h0);
    check("t5_zero", 32'(bus.rsp_zero), 32'h1);
    bus.rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    #1;
    check("t5_still_v", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'b01);
    check("t5_still_busy", 32'(bus.busy), 32'h1);
    await_rsp(1'b0, 32'h0);

    // 6: random traffic against the model
    apply_reset();
    run_cycles(10000, 1);
    run_cycles(30, 2);
    check("t6_all_done", 32'(n_done), 32'(n_acc));
    check("t6_activity", 32'(n_acc > 500), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
